dmem_bus_arbiter: RTL and testbench

Two-master arbiter for the CPU data bus, which is shared by the data memory and the memory-mapped peripheral block.
- Master 0 is the single-cycle CPU load/store port. Master 1 is a DMA/loader engine that uses a req/gnt handshake.
- Ownership is tracked in a registered owner flag. The bus mux follows the owner combinationally.
- The address prefix routes each access to the data memory or the peripheral block.
- When the DMA engine owns the bus and the CPU attempts an access, the CPU is stalled (PC held).

---
 rtl/dmem_bus_arbiter_pkg.sv | 26 ++
 rtl/dmem_bus_arbiter_decode.sv | 26 ++
 rtl/dmem_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_bus_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared definitions for the data-bus arbiter: owner encoding, the
// peripheral address prefix and a small prefix-match helper.
package dmem_bus_arbiter_pkg;

    // Owner flag encoding; the enum below is the state type of the arbiter FSM.
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    typedef enum logic {
        OWNER_CPU = OWN_CPU,
        OWNER_DMA = OWN_DMA
    } owner_e;

    // Value of addr[31:28] that selects the memory-mapped peripheral block.
    localparam logic [3:0] PERIPH_PREFIX = 4'b0100;

    // Width of the burst counter.
    localparam int BURST_W = 8;

    // True when the top address nibble selects the peripheral block.
    function automatic logic is_periph(input logic [3:0] addr_hi,
                                       input logic [3:0] prefix);
        return addr_hi == prefix;
    endfunction

endpackage

// File: rtl/dmem_bus_arbiter_decode.sv
// Combinational slave decode for the shared data bus: address prefix
// decode, write-strobe split and read-data select.
module dmem_bus_decode
    import dmem_bus_arbiter_pkg::*;
#(
    parameter logic [3:0] PREFIX = 4'b0100
) (
    input  logic [3:0]  addr_hi,
    input  logic        wr,
    input  logic [31:0] dm_rdata,
    input  logic [31:0] per_rdata,
    output logic        sel_per,
    output logic        dm_wr,
    output logic        per_wr,
    output logic [31:0] rdata
);

    // Route the write strobe and pick the read word from the addressed slave.
    always_comb begin
        sel_per = is_periph(addr_hi, PREFIX);
        dm_wr   = wr & ~sel_per;
        per_wr  = wr & sel_per;
        rdata   = sel_per ? per_rdata : dm_rdata;
    end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Two-master arbiter for the CPU data bus (data memory + peripheral block).
// Master 0 is the single-cycle CPU port, master 1 a DMA engine using a
// level req / registered gnt handshake. A registered owner flag steers the
// bus mux; a burst counter bounds how long one master can hold the bus
// while the other is waiting.
// Optional feature: define DMA_PERIPH_GUARD_EN to block DMA accesses to the
// peripheral block and report them with a one-cycle dma_err pulse.
module dmem_bus_arbiter #(
    parameter logic [3:0] PERIPH_PREFIX = dmem_bus_arbiter_pkg::PERIPH_PREFIX,
    parameter int         MAX_BURST     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_rd,
    input  logic        dma_wr,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_gnt,
    output logic        dma_err,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_rd,
    output logic        dm_wr,
    output logic        per_wr,
    input  logic [31:0] dm_rdata,
    input  logic [31:0] per_rdata
);

    import dmem_bus_arbiter_pkg::*;

    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    owner_e               owner;
    logic [BURST_W-1:0]   burst_cnt;
    logic                 cpu_acc;
    logic                 dma_acc;
    logic                 burst_last;
    logic                 dma_block;
    logic                 bus_wr;
    logic                 sel_per;
    logic [31:0]          rdata;

    assign cpu_acc    = cpu_rd | cpu_wr;
    assign dma_acc    = dma_gnt & dma_req & (dma_rd | dma_wr);
    assign burst_last = (burst_cnt == BURST_LAST);

`ifdef DMA_PERIPH_GUARD_EN
    logic dma_per_hit;

    assign dma_per_hit = dma_acc & is_periph(dma_addr[31:28], PERIPH_PREFIX);
    assign dma_block   = dma_per_hit;

    // Flag a blocked DMA peripheral access in the cycle that follows it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dma_err <= 1'b0;
        end else begin
            dma_err <= dma_per_hit;
        end
    end
`else
    assign dma_block = 1'b0;
    assign dma_err   = 1'b0;
`endif

    // Bus mux follows the owner flag; an idle DMA owner leaves all strobes low.
    always_comb begin
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_rd    = cpu_rd;
        bus_wr    = cpu_wr;
        if (owner == OWNER_DMA) begin
            bus_addr  = dma_addr;
            bus_wdata = dma_wdata;
            bus_rd    = dma_acc & dma_rd & ~dma_block;
            bus_wr    = dma_acc & dma_wr & ~dma_block;
        end
    end

    dmem_bus_decode #(
        .PREFIX(PERIPH_PREFIX)
    ) u_decode (
        .addr_hi  (bus_addr[31:28]),
        .wr       (bus_wr),
        .dm_rdata (dm_rdata),
        .per_rdata(per_rdata),
        .sel_per  (sel_per),
        .dm_wr    (dm_wr),
        .per_wr   (per_wr),
        .rdata    (rdata)
    );

    // Read data goes only to the current owner; a stalled CPU holds its PC.
    always_comb begin
        cpu_rdata = '0;
        dma_rdata = '0;
        cpu_stall = 1'b0;
        if (owner == OWNER_CPU) begin
            cpu_rdata = rdata;
        end else begin
            cpu_stall = cpu_acc;
            if (!(dma_block & sel_per)) begin
                dma_rdata = rdata;
            end
        end
    end

    // Owner FSM with registered grant and burst counter; switches land on cycle edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner     <= OWNER_CPU;
            dma_gnt   <= 1'b0;
            burst_cnt <= '0;
        end else begin
            case (owner)
                OWNER_CPU: begin
                    if (dma_req && (!cpu_acc || burst_last)) begin
                        owner     <= OWNER_DMA;
                        dma_gnt   <= 1'b1;
                        burst_cnt <= '0;
                    end else if (dma_req && cpu_acc) begin
                        burst_cnt <= burst_last ? burst_cnt : burst_cnt + 1'b1;
                    end else begin
                        burst_cnt <= '0;
                    end
                end
                OWNER_DMA: begin
                    if (!dma_req || (cpu_acc && dma_acc && burst_last)) begin
                        owner     <= OWNER_CPU;
                        dma_gnt   <= 1'b0;
                        burst_cnt <= '0;
                    end else if (!cpu_acc) begin
                        burst_cnt <= '0;
                    end else if (dma_acc) begin
                        burst_cnt <= burst_last ? burst_cnt : burst_cnt + 1'b1;
                    end
                end
                default: begin
                    owner     <= OWNER_CPU;
                    dma_gnt   <= 1'b0;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Self-checking bench for dmem_bus_arbiter (MAX_BURST=4). A behavioural
// owner/burst model is compared against the DUT every negative clock edge,
// alongside directed scenarios with hand-computed expectations.
module tb_dmem_bus_arbiter;

    localparam int         MAXB   = 4;
    localparam logic [3:0] PREFIX = 4'b0100;
`ifdef DMA_PERIPH_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        dma_req = 1'b0, dma_rd = 1'b0, dma_wr = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic [31:0] cpu_rdata, dma_rdata, bus_addr, bus_wdata, dm_rdata, per_rdata;
    logic        cpu_stall, dma_gnt, dma_err, bus_rd, dm_wr, per_wr;

    logic [31:0] mem [64];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    // Slave models: word-addressed data memory and an address-echo peripheral.
    assign dm_rdata  = mem[bus_addr[7:2]];
    assign per_rdata = {16'hA5A5, bus_addr[15:0]};

    dmem_bus_arbiter #(
        .PERIPH_PREFIX(PREFIX),
        .MAX_BURST    (MAXB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_rd   (cpu_rd),
        .cpu_wr   (cpu_wr),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dma_req  (dma_req),
        .dma_rd   (dma_rd),
        .dma_wr   (dma_wr),
        .dma_addr (dma_addr),
        .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata),
        .dma_gnt  (dma_gnt),
        .dma_err  (dma_err),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rd   (bus_rd),
        .dm_wr    (dm_wr),
        .per_wr   (per_wr),
        .dm_rdata (dm_rdata),
        .per_rdata(per_rdata)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic c_rd, input logic c_wr,
                                 input logic [31:0] c_addr, input logic [31:0] c_wdata,
                                 input logic d_req, input logic d_rd, input logic d_wr,
                                 input logic [31:0] d_addr, input logic [31:0] d_wdata);
        cpu_rd    = c_rd;
        cpu_wr    = c_wr;
        cpu_addr  = c_addr;
        cpu_wdata = c_wdata;
        dma_req   = d_req;
        dma_rd    = d_rd;
        dma_wr    = d_wr;
        dma_addr  = d_addr;
        dma_wdata = d_wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // Behavioural model: who owns the bus and how long its current run is.
    bit m_dma = 1'b0;
    int m_run = 0;
    bit m_err = 1'b0;
    bit u_cpu_busy, u_dma_busy, u_did, u_waits, u_switch;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_dma = 1'b0;
            m_run = 0;
            m_err = 1'b0;
        end else begin
            u_cpu_busy = cpu_rd || cpu_wr;
            u_dma_busy = m_dma && dma_req && (dma_rd || dma_wr);
            u_did      = m_dma ? u_dma_busy : u_cpu_busy;
            u_waits    = m_dma ? u_cpu_busy : dma_req;
            if (m_dma)
                u_switch = !dma_req || (u_cpu_busy && u_dma_busy && m_run == MAXB - 1);
            else
                u_switch = dma_req && (!u_cpu_busy || m_run == MAXB - 1);
            m_err = GUARD && u_dma_busy && (dma_addr[31:28] == PREFIX);
            if (u_switch) begin
                m_dma = !m_dma;
                m_run = 0;
            end else if (!u_waits) begin
                m_run = 0;
            end else if (u_did && m_run < MAXB - 1) begin
                m_run = m_run + 1;
            end
        end
    end

    // Memory slave commit: a strobed write lands on the closing edge unless reset intervenes.
    bit          pend = 1'b0;
    logic [31:0] pend_addr, pend_data;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend = 1'b0;
        end else if (pend) begin
            mem[pend_addr[7:2]] = pend_data;
            pend = 1'b0;
        end
    end

    // Compare process: every negedge, derive expected outputs from the model.
    bit          e_busy_d, e_rd, e_wr, e_per, e_block;
    logic [31:0] e_addr, e_wdata, e_word;

    always @(negedge clk) begin
        e_busy_d = m_dma && dma_req && (dma_rd || dma_wr);
        e_block  = 1'b0;
        if (m_dma) begin
            e_addr  = dma_addr;
            e_wdata = dma_wdata;
            e_rd    = e_busy_d && dma_rd;
            e_wr    = e_busy_d && dma_wr;
            e_block = GUARD && e_busy_d && (dma_addr[31:28] == PREFIX);
        end else begin
            e_addr  = cpu_addr;
            e_wdata = cpu_wdata;
            e_rd    = cpu_rd;
            e_wr    = cpu_wr;
        end
        if (e_block) begin
            e_rd = 1'b0;
            e_wr = 1'b0;
        end
        e_per  = (e_addr[31:28] == PREFIX);
        e_word = e_per ? {16'hA5A5, e_addr[15:0]} : mem[e_addr[7:2]];

        checkOutput("m_dma_gnt", {31'd0, dma_gnt}, {31'd0, m_dma});
        checkOutput("m_cpu_stall", {31'd0, cpu_stall}, {31'd0, m_dma && (cpu_rd || cpu_wr)});
        checkOutput("m_bus_rd", {31'd0, bus_rd}, {31'd0, e_rd});
        checkOutput("m_dm_wr", {31'd0, dm_wr}, {31'd0, e_wr && !e_per});
        checkOutput("m_per_wr", {31'd0, per_wr}, {31'd0, e_wr && e_per});
        checkOutput("m_dma_err", {31'd0, dma_err}, {31'd0, m_err});
        if (e_rd || e_wr) begin
            checkOutput("m_bus_addr", bus_addr, e_addr);
            checkOutput("m_bus_wdata", bus_wdata, e_wdata);
        end
        if (m_dma) begin
            checkOutput("m_cpu_rdata_zero", cpu_rdata, 32'd0);
            if (e_busy_d)
                checkOutput("m_dma_rdata", dma_rdata, e_block ? 32'd0 : e_word);
        end else begin
            checkOutput("m_cpu_rdata", cpu_rdata, e_word);
            checkOutput("m_dma_rdata_zero", dma_rdata, 32'd0);
        end
        if (dm_wr === 1'b1) begin
            pend      = 1'b1;
            pend_addr = bus_addr;
            pend_data = bus_wdata;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    int n;
    bit done;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        settle();
        checkOutput("reset_gnt", {31'd0, dma_gnt}, 32'd0);
        checkOutput("reset_stall", {31'd0, cpu_stall}, 32'd0);
        checkOutput("reset_err", {31'd0, dma_err}, 32'd0);
        tick();
        reset = 1'b1;

        // CPU store to data memory, then read it back.
        applyStimulus(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        settle();
        checkOutput("cpu_st_dm_wr", {31'd0, dm_wr}, 32'd1);
        checkOutput("cpu_st_per_wr", {31'd0, per_wr}, 32'd0);
        checkOutput("cpu_st_gnt", {31'd0, dma_gnt}, 32'd0);
        checkOutput("cpu_st_stall", {31'd0, cpu_stall}, 32'd0);
        tick();
        applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        settle();
        checkOutput("cpu_ld_10", cpu_rdata, 32'hDEADBEEF);

        // DMA request with CPU idle: grant one cycle later, DMA write lands.
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        settle();
        checkOutput("gnt_cycle0", {31'd0, dma_gnt}, 32'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 32'h20, 32'h12345678);
        settle();
        checkOutput("gnt_cycle1", {31'd0, dma_gnt}, 32'd1);
        checkOutput("dma_wr_dm", {31'd0, dm_wr}, 32'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checkOutput("gnt_hold_after_drop", {31'd0, dma_gnt}, 32'd1);
        tick();
        applyStimulus(1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
        settle();
        checkOutput("gnt_released", {31'd0, dma_gnt}, 32'd0);
        checkOutput("cpu_ld_20", cpu_rdata, 32'h12345678);

        // DMA owns, CPU load stream: exactly MAXB stalled DMA accesses.
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 32'h10, 0, 1, 0, 1, 32'h30, 32'h000000A0);
        settle();
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            if (cpu_stall === 1'b1) begin
                n++;
                tick();
                settle();
            end else begin
                done = 1'b1;
            end
        end
        checkOutput("stall_loop_done", {31'd0, done}, 32'd1);
        checkOutput("stall_cycles", n, 32'd4);
        checkOutput("cpu_back_gnt", {31'd0, dma_gnt}, 32'd0);
        checkOutput("cpu_back_rdata", cpu_rdata, 32'hDEADBEEF);

        // CPU load stream with DMA waiting: MAXB CPU accesses, then grant.
        n = 1;
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            tick();
            settle();
            if (dma_gnt === 1'b1) done = 1'b1;
            else n++;
        end
        checkOutput("cpu_burst_done", {31'd0, done}, 32'd1);
        checkOutput("cpu_burst_len", n, 32'd4);
        checkOutput("cpu_stalled_by_dma", {31'd0, cpu_stall}, 32'd1);

        // DMA accesses to the peripheral block.
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 32'h40000000, 32'hCAFE0001);
        settle();
        checkOutput("per_dm_wr", {31'd0, dm_wr}, 32'd0);
        checkOutput("per_err_same_cycle", {31'd0, dma_err}, 32'd0);
`ifdef DMA_PERIPH_GUARD_EN
        checkOutput("per_wr_guarded", {31'd0, per_wr}, 32'd0);
`else
        checkOutput("per_wr_open", {31'd0, per_wr}, 32'd1);
`endif
        tick();
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 32'h40000010, 0);
        settle();
`ifdef DMA_PERIPH_GUARD_EN
        checkOutput("per_err_pulse", {31'd0, dma_err}, 32'd1);
        checkOutput("per_rd_guarded", dma_rdata, 32'd0);
        checkOutput("per_bus_rd_guarded", {31'd0, bus_rd}, 32'd0);
`else
        checkOutput("per_err_tied", {31'd0, dma_err}, 32'd0);
        checkOutput("per_rd_open", dma_rdata, 32'hA5A50010);
`endif
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        settle();
`ifdef DMA_PERIPH_GUARD_EN
        checkOutput("per_err_after_rd", {31'd0, dma_err}, 32'd1);
`else
        checkOutput("per_err_after_rd", {31'd0, dma_err}, 32'd0);
`endif
        tick();
        settle();
        checkOutput("per_err_clear", {31'd0, dma_err}, 32'd0);

        // Reset in the middle of a DMA burst drops ownership immediately.
        tick();
        applyStimulus(1, 0, 32'h10, 0, 1, 0, 1, 32'h50, 32'hBAD0BAD0);
        settle();
        checkOutput("mid_gnt", {31'd0, dma_gnt}, 32'd1);
        checkOutput("mid_dm_wr", {31'd0, dm_wr}, 32'd1);
        checkOutput("mid_stall", {31'd0, cpu_stall}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("rst_gnt_now", {31'd0, dma_gnt}, 32'd0);
        checkOutput("rst_stall_now", {31'd0, cpu_stall}, 32'd0);
        checkOutput("rst_dm_wr_now", {31'd0, dm_wr}, 32'd0);
        checkOutput("rst_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        tick();
        settle();
        checkOutput("rst_gnt_held", {31'd0, dma_gnt}, 32'd0);
        checkOutput("rst_dm_wr_held", {31'd0, dm_wr}, 32'd0);
        tick();
        reset = 1'b1;
        applyStimulus(1, 0, 32'h50, 0, 1, 0, 1, 32'h50, 32'hBAD0BAD0);
        settle();
        checkOutput("post_rst_gnt", {31'd0, dma_gnt}, 32'd0);
        checkOutput("post_rst_dm_wr", {31'd0, dm_wr}, 32'd0);
        checkOutput("dropped_write", cpu_rdata, 32'd0);

        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        settle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
